// File: rtl/work_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : work_dispatcher                                              |
// | Description : Latches a 352-bit work word (midstate + header tail) from    |
// |               the byte-wide shift register, acknowledges it with a         |
// |               one-cycle sr_read, then sweeps the nonce range, issuing one  |
// |               {midstate, tail, nonce} beat per accepted handshake.         |
// |               Optional feature macro: WORK_PREEMPT_EN (a new work word     |
// |               arriving during RUN abandons the current job).               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module work_dispatcher #(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter int unsigned NONCE_STEP  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sr_full,
  input  logic [351:0] sr_data,
  output logic         sr_read,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [255:0] midstate,
  output logic [95:0]  tail,
  output logic [31:0]  nonce,
  output logic         busy,
  output logic         exhausted
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  // Step widened to 33 bits so the carry out of the nonce is the exhaustion flag
  localparam logic [32:0] c_step = 33'(NONCE_STEP);

  logic [1:0]   r_state;
  logic [255:0] r_midstate;
  logic [95:0]  r_tail;
  logic [31:0]  r_nonce;
  logic [32:0]  w_sum;

  // Next candidate nonce; bit 32 set means the range is used up
  assign w_sum = {1'b0, r_nonce} + c_step;

  // Job sequencing: capture work, acknowledge, sweep nonces, signal completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_midstate <= '0;
      r_tail     <= '0;
      r_nonce    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (sr_full) begin
            r_midstate <= sr_data[351:96];
            r_tail     <= sr_data[95:0];
            r_state    <= c_st_load;
          end
        end
        c_st_load: begin
          r_nonce <= NONCE_START;
          r_state <= c_st_run;
        end
        c_st_run: begin
`ifdef WORK_PREEMPT_EN
          // A waiting work word replaces the job on an accepted beat,
          // taking priority over exhaustion on the same beat.
          if (hash_ready && sr_full) begin
            r_midstate <= sr_data[351:96];
            r_tail     <= sr_data[95:0];
            r_state    <= c_st_load;
          end else
`endif
          if (hash_ready) begin
            if (w_sum[32]) begin
              r_state <= c_st_done;
            end else begin
              r_nonce <= w_sum[31:0];
            end
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign sr_read    = (r_state == c_st_load);
  assign hash_valid = (r_state == c_st_run);
  assign exhausted  = (r_state == c_st_done);
  assign busy       = (r_state != c_st_idle);
  assign midstate   = r_midstate;
  assign tail       = r_tail;
  assign nonce      = r_nonce;

endmodule
`default_nettype wire

// File: tb/tb_work_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_work_dispatcher                                           |
// | Description : Self-checking bench for work_dispatcher. Expected nonces     |
// |               come from START + k*STEP and the beat count from the range   |
// |               formula; ready is driven randomly or in fixed patterns.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_work_dispatcher;

  localparam logic [31:0] START = 32'hFFFF_FFEC;
  localparam int          STEP  = 3;

  logic         clk;
  logic         rst_n;
  logic         sr_full;
  logic [351:0] sr_data;
  logic         sr_read;
  logic         hash_valid;
  logic         hash_ready;
  logic [255:0] midstate;
  logic [95:0]  tail;
  logic [31:0]  nonce;
  logic         busy;
  logic         exhausted;

  int total = 0;
  int bad   = 0;

  work_dispatcher #(
    .NONCE_START (START),
    .NONCE_STEP  (STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sr_full    (sr_full),
    .sr_data    (sr_data),
    .sr_read    (sr_read),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .midstate   (midstate),
    .tail       (tail),
    .nonce      (nonce),
    .busy       (busy),
    .exhausted  (exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [351:0] rand_word();
    logic [351:0] w;
    for (int i = 0; i < 11; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Starts one edge before LOAD is expected (the capturing edge). Ends at
  // #1 into the first IDLE cycle after the job. mode: 0 random ready,
  // 1 ready always high, 2 ready pattern 1,0,0,1 repeating.
  task automatic sweep(input logic [351:0] word, input int mode,
                       input bit inject, input logic [351:0] word2);
    longint unsigned n_beats;
    longint unsigned k;
    int              cyc;
    bit              rdy;
    logic [31:0]     exp_nonce;
    n_beats = (64'hFFFF_FFFF - 64'(START)) / 64'(STEP) + 1;
    k   = 0;
    cyc = 0;
    @(posedge clk); #1;
    check("load_sr_read", sr_read, 1'b1);
    check("load_busy", busy, 1'b1);
    check("load_valid", hash_valid, 1'b0);
    check("load_midstate", midstate, word[351:96]);
    check("load_tail", tail, word[95:0]);
    sr_full = 1'b0;
    @(posedge clk); #1;
    while (k < n_beats && cyc < 400) begin
      exp_nonce = 32'(64'(START) + k * 64'(STEP));
      check("run_valid", hash_valid, 1'b1);
      check("run_nonce", nonce, exp_nonce);
      check("run_midstate", midstate, word[351:96]);
      check("run_tail", tail, word[95:0]);
      check("run_sr_read", sr_read, 1'b0);
      check("run_exhausted", exhausted, 1'b0);
      case (mode)
        0:       rdy = 1'($urandom_range(0, 1));
        1:       rdy = 1'b1;
        default: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      if (inject && cyc == 3) begin
        sr_data = word2;
        sr_full = 1'b1;
      end
      hash_ready = rdy;
      @(posedge clk); #1;
      if (rdy) k++;
      cyc++;
    end
    check("beat_count", k, n_beats);
    check("done_exhausted", exhausted, 1'b1);
    check("done_valid", hash_valid, 1'b0);
    check("done_sr_read", sr_read, 1'b0);
    hash_ready = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);
    check("idle_exhausted", exhausted, 1'b0);
    check("idle_sr_read", sr_read, 1'b0);
  endtask

  initial begin
    logic [351:0] w1, w2, w3, w4, w5, w6, w7;
    w1 = 352'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef01234567;
    w2 = rand_word();
    w3 = rand_word();
    w4 = rand_word();
    w5 = rand_word();
    w6 = rand_word();
    w7 = rand_word();

    rst_n      = 1'b0;
    sr_full    = 1'b0;
    sr_data    = '0;
    hash_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sr_read", sr_read, 1'b0);
    check("rst_valid", hash_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_exhausted", exhausted, 1'b0);
    check("rst_midstate", midstate, 256'd0);
    check("rst_tail", tail, 96'd0);
    check("rst_nonce", nonce, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_work", busy, 1'b0);

    // Known word, full throughput
    sr_data = w1;
    sr_full = 1'b1;
    sweep(w1, 1, 1'b0, '0);

    // Backpressure pattern and random ready
    sr_data = w2;
    sr_full = 1'b1;
    sweep(w2, 2, 1'b0, '0);
    sr_data = w3;
    sr_full = 1'b1;
    sweep(w3, 0, 1'b0, '0);

`ifndef WORK_PREEMPT_EN
    // New word arrives mid-job: held off until the dispatcher is idle again
    sr_data = w4;
    sr_full = 1'b1;
    sweep(w4, 0, 1'b1, w5);
    sweep(w5, 1, 1'b0, '0);
`endif

    // Asynchronous reset in the middle of a job
    sr_data = w6;
    sr_full = 1'b1;
    @(posedge clk); #1;
    sr_full = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", hash_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_nonce", nonce, 32'd0);
    check("midrst_midstate", midstate, 256'd0);
    check("midrst_sr_read", sr_read, 1'b0);
    sr_data = w7;
    sr_full = 1'b1;
    @(posedge clk); #1;
    check("inrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    sweep(w7, 1, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
